// File: rtl/spart_key_ctrl.sv
// spart_key_ctrl
// Turns received SPART bytes into one-hot movement keys for the CPU.
// Mapped bytes are queued in a small FIFO. A three-state FSM presents the
// head key until the CPU acknowledges it. Between consecutive keys there is
// always at least one cycle with SPART_we low.
//
// Optional feature: define SPART_KEY_REPEAT_EN to enable auto-repeat. When it
// is enabled and the queue stays empty in IDLE for REPEAT_DLY cycles, the last
// acknowledged key is presented again.
//
// Parameters
//   FIFO_DEPTH  key FIFO entries (power of two, 2..16)
//   REPEAT_DLY  auto-repeat idle interval in clk cycles (repeat build only)
// Ports
//   clk         single rising-edge clock
//   rst         synchronous active-high reset
//   rx_valid    one-cycle strobe, rx_data holds a received byte
//   rx_data     received ASCII byte
//   key_ack     CPU consumed the presented key
//   ovf_clr     clears the sticky overflow flag
//   SPART_we    key presented to CPU, held until acknowledged
//   SPART_keys  one-hot key code presented with SPART_we
//   key_count   FIFO occupancy
//   overflow    sticky, a mapped key was dropped because the FIFO was full
module spart_key_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int REPEAT_DLY = 1000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx_valid,
   input  logic [7:0]                    rx_data,
   input  logic                          key_ack,
   input  logic                          ovf_clr,
   output logic                          SPART_we,
   output logic [4:0]                    SPART_keys,
   output logic [$clog2(FIFO_DEPTH):0]   key_count,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   // Refuse to elaborate with a depth the pointer wrap cannot handle.
   generate
      if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) ||
          ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (REPEAT_DLY < 1)) begin : g_bad_params
         $error("spart_key_ctrl: illegal FIFO_DEPTH or REPEAT_DLY");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t        state;
   logic [4:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [4:0]    map_code;
   logic          mapped;
   logic          full;
   logic          pop;
   logic          push;

   // Byte to one-hot key translation. Zero means the byte is not a key.
   always_comb begin
      map_code = 5'h00;
      case (rx_data)
         8'h77, 8'h57: map_code = 5'h01;
         8'h73, 8'h53: map_code = 5'h02;
         8'h61, 8'h41: map_code = 5'h04;
         8'h64, 8'h44: map_code = 5'h08;
         8'h20:        map_code = 5'h10;
         default:      map_code = 5'h00;
      endcase
   end

   assign mapped = rx_valid && (map_code != 5'h00);
   assign full   = (key_count == CW'(FIFO_DEPTH));

`ifdef SPART_KEY_REPEAT_EN
   localparam int RW = $clog2(REPEAT_DLY + 1);

   logic [RW-1:0] rep_cnt;
   logic [4:0]    last_key;
   logic          rep_active;
   logic          rep_fire;

   // A repeat presentation does not come from the FIFO, so its ack must not pop.
   assign pop      = (state == ISSUE) && key_ack && !rep_active;
   assign rep_fire = (state == IDLE) && (key_count == '0) && !mapped &&
                     (rep_cnt == RW'(REPEAT_DLY - 1)) && (last_key != 5'h00);
`else
   assign pop = (state == ISSUE) && key_ack;
`endif

   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push = mapped && (!full || pop);

   // Storage array. It needs no reset because the pointers define which
   // entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= map_code;
      end
   end

   // FIFO pointers, occupancy, overflow flag and the presentation FSM.
   // Outputs are registered, so each state's output values are loaded on the
   // edge that enters that state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         key_count  <= '0;
         overflow   <= 1'b0;
         SPART_we   <= 1'b0;
         SPART_keys <= 5'h00;
`ifdef SPART_KEY_REPEAT_EN
         rep_cnt    <= '0;
         last_key   <= 5'h00;
         rep_active <= 1'b0;
`endif
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            key_count <= key_count + 1'b1;
         end else if (pop && !push) begin
            key_count <= key_count - 1'b1;
         end

         // A new drop takes priority over a clear in the same cycle.
         if (mapped && full && !pop) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end

`ifdef SPART_KEY_REPEAT_EN
         // Count idle cycles with an empty queue; saturate one short of the
         // limit so the repeat can still fire once a key is remembered.
         if ((state != IDLE) || mapped || rep_fire) begin
            rep_cnt <= '0;
         end else if ((key_count == '0) && (rep_cnt != RW'(REPEAT_DLY - 1))) begin
            rep_cnt <= rep_cnt + 1'b1;
         end
`endif

         case (state)
            IDLE: begin
               if (key_count != '0) begin
                  state      <= ISSUE;
                  SPART_we   <= 1'b1;
                  SPART_keys <= mem[rd_ptr];
`ifdef SPART_KEY_REPEAT_EN
                  rep_active <= 1'b0;
               end else if (rep_fire) begin
                  state      <= ISSUE;
                  SPART_we   <= 1'b1;
                  SPART_keys <= last_key;
                  rep_active <= 1'b1;
`endif
               end
            end
            ISSUE: begin
               if (key_ack) begin
                  state      <= GAP;
                  SPART_we   <= 1'b0;
                  SPART_keys <= 5'h00;
`ifdef SPART_KEY_REPEAT_EN
                  if (!rep_active) begin
                     last_key <= SPART_keys;
                  end
                  rep_active <= 1'b0;
`endif
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state      <= IDLE;
               SPART_we   <= 1'b0;
               SPART_keys <= 5'h00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spart_key_ctrl.sv
// tb_spart_key_ctrl
// Self-checking bench for spart_key_ctrl. Stimulus pushes the keys it expects
// the CPU to see into a queue. A monitor pops that queue each time a new
// presentation starts. Occupancy and overflow are compared directly against
// hand-computed values.
module tb_spart_key_ctrl;

   logic       clk;
   logic       rst;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       key_ack;
   logic       ovf_clr;
   logic       SPART_we;
   logic [4:0] SPART_keys;
   logic [2:0] key_count;
   logic       overflow;

   int         checks;
   int         passes;
   logic [4:0] expQ[$];
   logic       prevWe;

   spart_key_ctrl #(
      .FIFO_DEPTH(4),
      .REPEAT_DLY(10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .key_ack    (key_ack),
      .ovf_clr    (ovf_clr),
      .SPART_we   (SPART_we),
      .SPART_keys (SPART_keys),
      .key_count  (key_count),
      .overflow   (overflow)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value with its required value and keep score.
   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act == exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one received byte for a single cycle.
   task automatic applyStimulus(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   // Wait, bounded, for a presentation to be on the outputs.
   task automatic waitWe();
      int n;
      n = 0;
      while (!SPART_we && n < 50) begin
         tick();
         n++;
      end
      if (!SPART_we) begin
         checks++;
         $display("[TB] FAIL wait for SPART_we: got 0, required 1 within 50 cycles");
      end
   endtask

   // Acknowledge the next presented key with a one-cycle pulse.
   task automatic ackOnce();
      waitWe();
      key_ack = 1'b1;
      tick();
      key_ack = 1'b0;
   endtask

   // Monitor: each rising edge of SPART_we is one presentation, and it must
   // match the oldest expected key. Sampled on the falling edge.
   initial prevWe = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prevWe = 1'b0;
      end else begin
         if (SPART_we && !prevWe) begin
            if (expQ.size() == 0) begin
               checks++;
               $display("[TB] FAIL unexpected key: got %0d, required none", SPART_keys);
            end else begin
               checkOutput("presented key", SPART_keys, expQ.pop_front());
            end
         end
         prevWe = SPART_we;
      end
   end

   // Directed sequence.
   initial begin
      checks   = 0;
      passes   = 0;
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      key_ack  = 1'b0;
      ovf_clr  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset SPART_we", SPART_we, 0);
      checkOutput("reset SPART_keys", SPART_keys, 0);
      checkOutput("reset key_count", key_count, 0);
      checkOutput("reset overflow", overflow, 0);

`ifdef SPART_KEY_REPEAT_EN
      // Space acked once, then left alone: it must come back by itself.
      expQ.push_back(5'h10);
      expQ.push_back(5'h10);
      key_ack = 1'b1;
      applyStimulus(8'h20);
      tick();
      tick();
      key_ack = 1'b0;
      checkOutput("repeat popped count", key_count, 0);
      waitWe();
      checkOutput("repeat key_count", key_count, 0);
      checkOutput("repeat key", SPART_keys, 5'h10);
      ackOnce();
      checkOutput("repeat ack no pop", key_count, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
`else
      // 'd' with ack tied high: one-cycle presentation one edge after the push.
      expQ.push_back(5'h08);
      key_ack = 1'b1;
      applyStimulus("d");
      checkOutput("d pushed count", key_count, 1);
      checkOutput("d not yet presented", SPART_we, 0);
      tick();
      checkOutput("d SPART_we", SPART_we, 1);
      checkOutput("d SPART_keys", SPART_keys, 5'h08);
      tick();
      checkOutput("d one cycle only", SPART_we, 0);
      checkOutput("d count drained", key_count, 0);
      key_ack = 1'b0;
      repeat (3) tick();

      // 'w','x','a' without ack: 'x' is discarded, 'w' is held.
      expQ.push_back(5'h01);
      expQ.push_back(5'h04);
      applyStimulus("w");
      applyStimulus("x");
      applyStimulus("a");
      checkOutput("wxa key_count", key_count, 2);
      checkOutput("wxa SPART_we", SPART_we, 1);
      repeat (3) tick();
      checkOutput("wxa held key", SPART_keys, 5'h01);
      ackOnce();
      checkOutput("gap cycle SPART_we", SPART_we, 0);
      checkOutput("gap cycle key_count", key_count, 1);
      ackOnce();
      checkOutput("wxa drained", key_count, 0);
      repeat (3) tick();

      // Five mapped bytes into a depth-4 FIFO: the fifth is dropped.
      expQ.push_back(5'h01);
      expQ.push_back(5'h02);
      expQ.push_back(5'h04);
      expQ.push_back(5'h08);
      applyStimulus("w");
      applyStimulus("s");
      applyStimulus("a");
      applyStimulus("d");
      applyStimulus(" ");
      checkOutput("full key_count", key_count, 4);
      checkOutput("full overflow", overflow, 1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checkOutput("ovf_clr clears", overflow, 0);
      // Drop and clear in the same cycle: the drop wins.
      ovf_clr = 1'b1;
      applyStimulus("W");
      ovf_clr = 1'b0;
      checkOutput("set wins over clear", overflow, 1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checkOutput("ovf cleared again", overflow, 0);

      // Full FIFO, 'S' arrives together with the ack: push accepted.
      expQ.push_back(5'h02);
      key_ack = 1'b1;
      applyStimulus("S");
      key_ack = 1'b0;
      checkOutput("push+pop key_count", key_count, 4);
      checkOutput("push+pop overflow", overflow, 0);
      repeat (4) ackOnce();
      tick();
      checkOutput("all drained", key_count, 0);
      repeat (3) tick();

      // Reset during ISSUE with three keys queued: nothing is presented later.
      expQ.push_back(5'h01);
      applyStimulus("w");
      applyStimulus("a");
      applyStimulus("d");
      checkOutput("pre-reset key_count", key_count, 3);
      checkOutput("pre-reset SPART_we", SPART_we, 1);
      rst     = 1'b1;
      key_ack = 1'b1;
      tick();
      rst     = 1'b0;
      key_ack = 1'b0;
      checkOutput("mid-issue reset SPART_we", SPART_we, 0);
      checkOutput("mid-issue reset key_count", key_count, 0);
      repeat (20) tick();
      checkOutput("post-reset SPART_we", SPART_we, 0);
      checkOutput("post-reset key_count", key_count, 0);
`endif

      checkOutput("scoreboard drained", expQ.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/spart_key_ctrl.md
SPART_KEY_CTRL -- requirements
Module: spart_key_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, key FIFO entries (power of two, 2..16).
REQ-002 Parameter REPEAT_DLY, default 1000, auto-repeat idle interval in clk cycles (used only with SPART_KEY_REPEAT_EN).
REQ-003 Port clk  input  1  single clock; all logic rising-edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port rx_valid  input  1  one-cycle strobe: rx_data holds a received SPART byte.
REQ-006 Port rx_data  input  8  received ASCII byte.
REQ-007 Port key_ack  input  1  CPU has consumed the presented key (pulse from key-read instruction).
REQ-008 Port ovf_clr  input  1  clears the overflow flag.
REQ-009 Port SPART_we  output  1  key presented to CPU, held until acknowledged.
REQ-010 Port SPART_keys  output  5  one-hot key code presented with SPART_we.
REQ-011 Port key_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-012 Port overflow  output  1  sticky: a mapped key was dropped.

Function
REQ-013 Byte map: 'w'/'W'->5'h01, 's'/'S'->5'h02, 'a'/'A'->5'h04, 'd'/'D'->5'h08, 0x20 (space)->5'h10; every other byte is discarded with no state change.
REQ-014 A mapped byte is written into the FIFO at the clock edge of its rx_valid cycle; key_count increments that same edge.
REQ-015 FSM states IDLE, ISSUE, GAP; exactly one state active.
REQ-016 IDLE: SPART_we=0, SPART_keys=0; if key_count!=0, next state ISSUE with SPART_keys loaded from FIFO head.
REQ-017 ISSUE: SPART_we=1, SPART_keys stable; on key_ack pop head (key_count decrements that edge), next state GAP; without key_ack remain in ISSUE indefinitely.
REQ-018 GAP: SPART_we=0, SPART_keys=0 for exactly one cycle, then IDLE; consecutive keys are therefore separated by at least one deasserted cycle.
REQ-019 key_ack outside ISSUE is ignored.
REQ-020 Latency: key arriving to an empty FIFO in IDLE reaches SPART_we=1 two edges after its rx_valid edge.
REQ-021 Full FIFO with mapped rx_valid and no pop that cycle: byte dropped, FIFO unchanged, overflow set next edge.
REQ-022 Full FIFO with mapped rx_valid and pop in the same cycle: push accepted, key_count unchanged, overflow not set.
REQ-023 Empty FIFO never pops; read/write pointers wrap modulo FIFO_DEPTH.
REQ-024 ovf_clr clears overflow; if ovf_clr and a new overflow occur in the same cycle, overflow is set (set wins).

Reset
REQ-025 rst forces state IDLE, FIFO empty (pointers 0, key_count 0), SPART_we 0, SPART_keys 0, overflow 0, repeat counter and last-key register 0 on the next edge.
REQ-026 rst during ISSUE drops the presented key with no pop; key_ack in the reset cycle is ignored.

Configuration
REQ-027 Macro SPART_KEY_REPEAT_EN compiled in: a last-key register captures each key popped in ISSUE; a counter counts IDLE cycles with key_count 0, clears on any mapped rx_valid or non-IDLE state; on reaching REPEAT_DLY with last-key nonzero, FSM enters ISSUE presenting last-key without touching the FIFO, and counter clears.
REQ-028 Macro not defined: no last-key register or counter exists; block presents only FIFO keys.

Verification
REQ-029 Byte 'd' with key_ack tied 1 -> SPART_we=1 and SPART_keys=5'h08 for one cycle, two edges after rx_valid, key_count back to 0.
REQ-030 Bytes 'w','x','a' with key_ack held 0 -> key_count=2, SPART_keys=5'h01 held; then ack twice -> 5'h01, GAP cycle, 5'h04.
REQ-031 Five mapped bytes, DEPTH 4, no ack -> key_count=4, overflow=1; ovf_clr -> overflow=0.
REQ-032 Full FIFO, rx_valid 'S' in the same cycle as key_ack -> key_count stays 4, overflow stays 0, 5'h02 presented last.
REQ-033 rst asserted mid-ISSUE with 3 queued -> next edge SPART_we=0, key_count=0; no key presented afterward.
REQ-034 SPART_KEY_REPEAT_EN, REPEAT_DLY=10: ' ' acked, no further input -> 5'h10 re-presented after 10 idle cycles, key_count stays 0.
